// File: rtl/bitstream_serializer_if.sv
// Handshake/stream bundle for bitstream_serializer.
//   in_data/in_valid/in_ready : parallel word handshake (producer -> serializer)
//   x/x_valid                 : serial bit stream toward a bit-serial detector
//   busy/done                 : word-in-flight status and final-bit pulse
// master modport = word producer / stream consumer side, slave = serializer side.
interface bitstream_serializer_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;

  modport master (
    output in_data, in_valid,
    input  in_ready, x, x_valid, busy, done
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, x, x_valid, busy, done
  );
endinterface

// File: rtl/bitstream_serializer.sv
// bitstream_serializer: takes WIDTH-bit words over valid/ready and shifts them out
// one bit per clock on x, feeding a bit-serial sequence detector. Back-to-back words
// produce a gap-free stream so patterns spanning word boundaries stay visible.
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   bus  : bitstream_serializer_if.slave (in_data, in_valid, in_ready, x, x_valid,
//          busy, done)
// Parameters: WIDTH (>=2), MSB_FIRST (1: in_data[WIDTH-1] first), GAP (0..15 idle
// cycles after each word).
// Optional feature macro: SER_PARITY_EN -- appends an even-parity bit (^word) after
// the data bits; done moves to that parity cycle. Undefined: no PARITY state at all.
// x, x_valid, done and busy are registered; in_ready is decoded from state and bit
// count only, never from in_valid.
module bitstream_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input logic                  clk,
  input logic                  rst,
  bitstream_serializer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef SER_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd2;
`endif
  localparam logic [1:0] ST_GAP    = 2'd3;
  // Where a finished word goes when nothing new is accepted on its final bit.
  localparam logic [1:0] ST_AFTER  = (GAP > 0) ? ST_GAP : ST_IDLE;

  logic [1:0]       state, nxt_state;
  logic [CW-1:0]    cnt, nxt_cnt;
  logic [3:0]       gcnt, nxt_gcnt;
  logic [WIDTH-1:0] sh, nxt_sh;
  logic             x_q, nxt_x;
  logic             xv_q, nxt_xv;
  logic             done_q, nxt_done;
  logic             busy_q;
  logic             ready;
  logic             accept;
`ifdef SER_PARITY_EN
  logic             par_q, nxt_par;
`endif

  // Bit that goes out next from a word/residue held in the shift register.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) return w[WIDTH-1];
    else                return w[0];
  endfunction

  // Drop the bit just emitted so the following one sits at the output end.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) return {w[WIDTH-2:0], 1'b0};
    else                return {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready in IDLE, and on the final emitted bit when no gap follows, so the next
  // word's first bit lands on the very next cycle.
  always_comb begin
    ready = 1'b0;
    case (state)
      ST_IDLE:   ready = 1'b1;
`ifdef SER_PARITY_EN
      ST_SHIFT:  ready = 1'b0;
      ST_PARITY: ready = (GAP == 0);
`else
      ST_SHIFT:  ready = (GAP == 0) && (cnt == LAST);
`endif
      default:   ready = 1'b0;
    endcase
  end

  assign accept = bus.in_valid && ready;

  // Next-state and next-output decode. Outputs are computed one cycle ahead and
  // registered, so the register x_q always holds the bit of the current cycle.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_gcnt  = gcnt;
    nxt_sh    = sh;
    nxt_x     = 1'b0;
    nxt_xv    = 1'b0;
    nxt_done  = 1'b0;
`ifdef SER_PARITY_EN
    nxt_par   = par_q;
`endif
    if (accept) begin
      // First bit goes out directly; the register keeps the remaining bits.
      nxt_state = ST_SHIFT;
      nxt_cnt   = '0;
      nxt_sh    = shift_once(bus.in_data);
      nxt_x     = first_bit(bus.in_data);
      nxt_xv    = 1'b1;
`ifdef SER_PARITY_EN
      nxt_par   = ^bus.in_data;
`endif
    end else begin
      case (state)
        ST_SHIFT: begin
          if (cnt != LAST) begin
            nxt_cnt = cnt + 1'b1;
            nxt_x   = first_bit(sh);
            nxt_sh  = shift_once(sh);
            nxt_xv  = 1'b1;
`ifdef SER_PARITY_EN
            nxt_done = 1'b0;
`else
            // The bit being loaded is the last data bit of the word.
            nxt_done = (cnt == PRE_LAST);
`endif
          end else begin
`ifdef SER_PARITY_EN
            nxt_state = ST_PARITY;
            nxt_x     = par_q;
            nxt_xv    = 1'b1;
            nxt_done  = 1'b1;
`else
            nxt_state = ST_AFTER;
            nxt_gcnt  = '0;
`endif
          end
        end
`ifdef SER_PARITY_EN
        ST_PARITY: begin
          nxt_state = ST_AFTER;
          nxt_gcnt  = '0;
        end
`endif
        ST_GAP: begin
          if (gcnt == GAP_LAST) nxt_state = ST_IDLE;
          else                  nxt_gcnt  = gcnt + 1'b1;
        end
        default: nxt_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      gcnt   <= '0;
      sh     <= '0;
      x_q    <= 1'b0;
      xv_q   <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef SER_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      state  <= nxt_state;
      cnt    <= nxt_cnt;
      gcnt   <= nxt_gcnt;
      sh     <= nxt_sh;
      x_q    <= nxt_x;
      xv_q   <= nxt_xv;
      done_q <= nxt_done;
      busy_q <= (nxt_state != ST_IDLE);
`ifdef SER_PARITY_EN
      par_q  <= nxt_par;
`endif
    end
  end

  assign bus.in_ready = ready;
  assign bus.x        = x_q;
  assign bus.x_valid  = xv_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_bitstream_serializer.sv
// Self-checking bench for bitstream_serializer. Three instances (WIDTH=4):
//   0: MSB first, no gap   1: LSB first, no gap   2: MSB first, GAP=2
// Directed scenarios check fixed expected streams; the random phase checks every
// cycle against a queue-based model of the emitted stream.
module tb_bitstream_serializer;
  localparam int W = 4;
  localparam int N = 3;
`ifdef SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = W + PAR;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bitstream_serializer_if #(.WIDTH(W)) if0 ();
  bitstream_serializer_if #(.WIDTH(W)) if1 ();
  bitstream_serializer_if #(.WIDTH(W)) if2 ();

  bitstream_serializer #(.WIDTH(W), .MSB_FIRST(1), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  bitstream_serializer #(.WIDTH(W), .MSB_FIRST(0), .GAP(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  bitstream_serializer #(.WIDTH(W), .MSB_FIRST(1), .GAP(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic [W-1:0] din [N];
  logic         vin [N];
  logic         rdy [N];
  logic         xo  [N];
  logic         xv  [N];
  logic         bsy [N];
  logic         dn  [N];

  assign if0.in_data = din[0];  assign if0.in_valid = vin[0];
  assign if1.in_data = din[1];  assign if1.in_valid = vin[1];
  assign if2.in_data = din[2];  assign if2.in_valid = vin[2];
  assign rdy[0] = if0.in_ready; assign xo[0] = if0.x; assign xv[0] = if0.x_valid;
  assign bsy[0] = if0.busy;     assign dn[0] = if0.done;
  assign rdy[1] = if1.in_ready; assign xo[1] = if1.x; assign xv[1] = if1.x_valid;
  assign bsy[1] = if1.busy;     assign dn[1] = if1.done;
  assign rdy[2] = if2.in_ready; assign xo[2] = if2.x; assign xv[2] = if2.x_valid;
  assign bsy[2] = if2.busy;     assign dn[2] = if2.done;

  int tests = 0;
  int fails = 0;

  // ---------------- reference model: queue of future output cycles ----------------
  typedef struct packed {
    logic x;
    logic xv;
    logic dn;
    logic busy;
    logic gap;
  } ent_t;

  ent_t mq [N][$];
  ent_t cur [N];

  function automatic int cfg_msb(int k);
    return (k == 1) ? 0 : 1;
  endfunction

  function automatic int cfg_gap(int k);
    return (k == 2) ? 2 : 0;
  endfunction

  // A new word fits only when nothing is scheduled past the current cycle and the
  // current cycle is not one of the idle gap cycles.
  function automatic logic m_ready(int k);
    return (mq[k].size() == 0) && !cur[k].gap;
  endfunction

  task automatic m_accept(int k, logic [W-1:0] w);
    ent_t e;
    for (int i = 0; i < W; i++) begin
      e.x    = (cfg_msb(k) != 0) ? w[W-1-i] : w[i];
      e.xv   = 1'b1;
      e.dn   = (PAR == 0) && (i == W - 1);
      e.busy = 1'b1;
      e.gap  = 1'b0;
      mq[k].push_back(e);
    end
    for (int p = 0; p < PAR; p++) begin
      e.x = ^w; e.xv = 1'b1; e.dn = 1'b1; e.busy = 1'b1; e.gap = 1'b0;
      mq[k].push_back(e);
    end
    for (int g = 0; g < cfg_gap(k); g++) begin
      e.x = 1'b0; e.xv = 1'b0; e.dn = 1'b0; e.busy = 1'b1; e.gap = 1'b1;
      mq[k].push_back(e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin vin[k] = 1'b0; din[k] = '0; end
    repeat (2) tick;
    for (int k = 0; k < N; k++) begin
      tests++;
      if ({xo[k], xv[k], dn[k], bsy[k], rdy[k]} !== 5'b00001) begin
        fails++;
        $display("FAIL reset inst%0d got={x,xv,done,busy,rdy}=%b exp=00001",
                 k, {xo[k], xv[k], dn[k], bsy[k], rdy[k]});
      end
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_msb_word;
    logic [4:0] bits;
    logic [4:0] got, exp;
    bits = 5'b10100;                      // 1,0,1,0 then parity of 1010 = 0
    din[0] = 4'b1010; vin[0] = 1'b1;
    tests++;
    if (rdy[0] !== 1'b1) begin
      fails++; $display("FAIL msb_word idle_ready got=%b exp=1", rdy[0]);
    end
    for (int c = 1; c <= NB + 1; c++) begin
      tick;
      vin[0] = 1'b0;
      got = {xo[0], xv[0], dn[0], bsy[0], rdy[0]};
      if (c <= NB) exp = {bits[5-c], 1'b1, (c == NB), 1'b1, (c == NB)};
      else         exp = 5'b00001;
      tests++;
      if (got !== exp) begin
        fails++; $display("FAIL msb_word cyc%0d got=%b exp=%b", c, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] s, exp_s;
    logic [1:0] got, exp;
    s = '0;
    din[0] = 4'b1010; vin[0] = 1'b1;
    for (int c = 1; c <= 2 * NB; c++) begin
      tick;
      if (c == NB + 1) vin[0] = 1'b0;
      s = {s[8:0], xo[0]};
      got = {xv[0], rdy[0]};
      exp = {1'b1, (c == NB) || (c == 2 * NB)};
      tests++;
      if (got !== exp) begin
        fails++; $display("FAIL b2b cyc%0d got={xv,rdy}=%b exp=%b", c, got, exp);
      end
    end
    tick;
    tests++;
    if (xv[0] !== 1'b0) begin
      fails++; $display("FAIL b2b tail_xv got=%b exp=0", xv[0]);
    end
    exp_s = (PAR != 0) ? 10'b1010010100 : 10'b0010101010;
    tests++;
    if (s !== exp_s) begin
      fails++; $display("FAIL b2b stream got=%b exp=%b", s, exp_s);
    end
`ifndef SER_PARITY_EN
    begin
      // 1010 overlapping detector: z on the bit that completes the pattern.
      logic [3:0] win;
      logic [7:0] z;
      win = '0; z = '0;
      for (int i = 0; i < 8; i++) begin
        win = {win[2:0], s[7-i]};
        z[i] = (i >= 3) && (win == 4'b1010);
      end
      tests++;
      if (z !== 8'b10101000) begin
        fails++; $display("FAIL b2b detector_z got=%b exp=10101000", z);
      end
    end
`endif
  endtask

  task automatic test_lsb_ignore;
    logic [9:0] s, exp_s;
    logic [1:0] got, exp;
    s = '0;
    din[1] = 4'b0101; vin[1] = 1'b1;
    for (int c = 1; c <= 2 * NB; c++) begin
      tick;
      if (c == 1) din[1] = 4'hF;          // held valid while busy: must be ignored
      if (c == NB + 1) vin[1] = 1'b0;
      s = {s[8:0], xo[1]};
      got = {xv[1], rdy[1]};
      exp = {1'b1, (c == NB) || (c == 2 * NB)};
      tests++;
      if (got !== exp) begin
        fails++; $display("FAIL lsb cyc%0d got={xv,rdy}=%b exp=%b", c, got, exp);
      end
    end
    tick;
    exp_s = (PAR != 0) ? 10'b1010011110 : 10'b0010101111;
    tests++;
    if ({s, xv[1]} !== {exp_s, 1'b0}) begin
      fails++; $display("FAIL lsb stream got=%b/%b exp=%b/0", s, xv[1], exp_s);
    end
  endtask

  task automatic test_gap;
    logic [4:0] bits;
    logic [4:0] got, exp;
    bits = 5'b11000;                      // 1,1,0,0 then parity of 1100 = 0
    din[2] = 4'b1100; vin[2] = 1'b1;
    for (int c = 1; c <= NB + 3; c++) begin
      tick;
      vin[2] = 1'b0;
      got = {xo[2], xv[2], dn[2], bsy[2], rdy[2]};
      if (c <= NB)          exp = {bits[5-c], 1'b1, (c == NB), 1'b1, 1'b0};
      else if (c <= NB + 2) exp = 5'b00010;
      else                  exp = 5'b00001;
      tests++;
      if (got !== exp) begin
        fails++; $display("FAIL gap cyc%0d got=%b exp=%b", c, got, exp);
      end
    end
  endtask

  task automatic test_mid_reset;
    din[0] = 4'b1111; vin[0] = 1'b1;
    tick;
    vin[0] = 1'b0;
    tick;
    tests++;
    if ({xo[0], xv[0]} !== 2'b11) begin
      fails++; $display("FAIL midrst cyc2 got={x,xv}=%b exp=11", {xo[0], xv[0]});
    end
    rst = 1'b1;
    tick;
    tests++;
    if ({xo[0], xv[0], dn[0], bsy[0], rdy[0]} !== 5'b00001) begin
      fails++; $display("FAIL midrst after_rst got=%b exp=00001",
                        {xo[0], xv[0], dn[0], bsy[0], rdy[0]});
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      tests++;
      if ({xv[0], bsy[0], dn[0]} !== 3'b000) begin
        fails++; $display("FAIL midrst resid%0d got={xv,busy,done}=%b exp=000",
                          c, {xv[0], bsy[0], dn[0]});
      end
    end
  endtask

`ifdef SER_PARITY_EN
  task automatic test_parity;
    logic [3:0] words [2];
    logic [4:0] exps [2];
    logic [4:0] s, dmask;
    words[0] = 4'b1011; exps[0] = 5'b10111;
    words[1] = 4'b1001; exps[1] = 5'b10010;
    for (int j = 0; j < 2; j++) begin
      s = '0; dmask = '0;
      din[0] = words[j]; vin[0] = 1'b1;
      for (int c = 1; c <= 5; c++) begin
        tick;
        vin[0] = 1'b0;
        s = {s[3:0], xo[0]};
        dmask = {dmask[3:0], dn[0]};
      end
      tests++;
      if ({s, dmask} !== {exps[j], 5'b00001}) begin
        fails++; $display("FAIL parity word%0d got=%b done=%b exp=%b done=00001",
                          j, s, dmask, exps[j]);
      end
      tick;
    end
  endtask
`endif

  task automatic test_random;
    logic [4:0] got, exp;
    rst = 1'b1;
    for (int k = 0; k < N; k++) vin[k] = 1'b0;
    tick;
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin mq[k].delete(); cur[k] = '0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < N; k++) begin
        vin[k] = ($urandom_range(0, 3) != 0);
        din[k] = W'($urandom);
      end
      rst = ($urandom_range(0, 99) == 0);
      @(posedge clk);
      for (int k = 0; k < N; k++) begin
        if (rst) begin
          mq[k].delete();
          cur[k] = '0;
        end else begin
          if (vin[k] && m_ready(k)) m_accept(k, din[k]);
          if (mq[k].size() != 0) cur[k] = mq[k].pop_front();
          else                   cur[k] = '0;
        end
      end
      #1;
      for (int k = 0; k < N; k++) begin
        got = {xo[k], xv[k], dn[k], bsy[k], rdy[k]};
        exp = {cur[k].x, cur[k].xv, cur[k].dn, cur[k].busy, m_ready(k)};
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL random inst%0d cyc%0d got={x,xv,done,busy,rdy}=%b exp=%b",
                   k, cyc, got, exp);
        end
      end
    end
    rst = 1'b0;
    for (int k = 0; k < N; k++) vin[k] = 1'b0;
    repeat (4) tick;
  endtask

  initial begin
    test_reset;
    test_msb_word;
    tick;
    test_back_to_back;
    tick;
    test_lsb_ignore;
    tick;
    test_gap;
    tick;
    test_mid_reset;
    tick;
`ifdef SER_PARITY_EN
    test_parity;
`endif
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
